motor_ramp_ctrl: RTL

Speed-command sequencer that sits in front of `motor_drv` and drives its `enable`, `direction` and `duty_cycle` inputs. Accepts signed speed targets over a valid/ready handshake and slews the duty cycle toward them at a programmable rate. On a sign change it ramps to zero, holds a dead-time dwell, flips direction, then ramps up. Provides an emergency stop and status flags for a host or supervisor.

---
 rtl/motor_ramp_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl
// Speed-command sequencer in front of motor_drv. Accepts signed speed
// targets over a valid/ready handshake and slews the duty cycle toward them
// one step per prescaler tick. A sign change ramps to zero, waits out a
// dead-time dwell, flips direction and ramps back up. estop forces zero duty.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous reset, active-low
//   cmd_valid     in   command present
//   cmd_ready     out  command accepted when cmd_valid & cmd_ready
//   cmd_speed     in   signed target, -255..+255 (-256 treated as -255)
//   cmd_step      in   duty change per tick (0 treated as 1)
//   estop         in   synchronous emergency stop, level-sensitive
//   drv_enable    out  motor_drv.enable
//   drv_direction out  motor_drv.direction, 1 = positive speed
//   drv_duty      out  motor_drv.duty_cycle
//   busy          out  ramping or dwelling
//   at_target     out  holding a target, or idle
module motor_ramp_ctrl #(
  parameter int CLK_HZ      = 25000000,
  parameter int STEP_HZ     = 1000,
  parameter int DWELL_TICKS = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic signed [8:0] cmd_speed,
  input  logic        [7:0] cmd_step,
  input  logic              estop,
  output logic              drv_enable,
  output logic              drv_direction,
  output logic        [7:0] drv_duty,
  output logic              busy,
  output logic              at_target
);

  localparam int PERIOD = CLK_HZ / STEP_HZ;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DWW    = $clog2(DWELL_TICKS + 1);
  localparam logic [PW-1:0]  PCNT_LAST  = PW'(PERIOD - 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_DWELL, S_HOLD} state_t;

  // Magnitude of a signed speed, folding -256 onto 255.
  function automatic logic [7:0] speed_mag(input logic signed [8:0] s);
    logic signed [8:0] neg;
    neg = -s;
    if (s == -9'sd256)   return 8'd255;
    else if (s < 9'sd0)  return neg[7:0];
    else                 return s[7:0];
  endfunction

  // One ramp step toward goal; lands exactly on goal when within one step.
  function automatic logic [7:0] ramp_step(input logic [7:0] duty,
                                           input logic [7:0] goal,
                                           input logic [7:0] step);
    logic [8:0] diff;
    if (duty < goal) begin
      diff = {1'b0, goal} - {1'b0, duty};
      if (diff <= {1'b0, step}) return goal;
      else                      return duty + step;
    end else begin
      diff = {1'b0, duty} - {1'b0, goal};
      if (diff <= {1'b0, step}) return goal;
      else                      return duty - step;
    end
  endfunction

  state_t         r_state, w_state_n;
  logic [PW-1:0]  r_pcnt;
  logic [7:0]     r_duty, w_duty_n;
  logic           r_dir, w_dir_n;
  logic [7:0]     r_tgt, w_tgt_n;
  logic [7:0]     r_step, w_step_n;
  logic           r_rev_pend, w_rev_n;
  logic [DWW-1:0] r_dwell, w_dwell_n;
  logic           r_ready_st, r_enable, r_busy, r_at_target;

  logic           w_tick;
  logic           w_accept;
  logic           w_sgn;
  logic [7:0]     w_goal;

  // Free-running prescaler; commands never disturb its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
    end else if (r_pcnt == PCNT_LAST) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  assign w_tick    = (r_pcnt == PCNT_LAST);
  assign cmd_ready = r_ready_st & ~estop;
  assign w_accept  = cmd_valid & cmd_ready;
  // A zero target keeps the current direction so it never triggers a reversal.
  assign w_sgn     = (cmd_speed == 9'sd0) ? r_dir : (cmd_speed > 9'sd0);
  assign w_goal    = r_rev_pend ? 8'd0 : r_tgt;

  always_comb begin
    w_state_n = r_state;
    w_duty_n  = r_duty;
    w_dir_n   = r_dir;
    w_tgt_n   = r_tgt;
    w_step_n  = r_step;
    w_rev_n   = r_rev_pend;
    w_dwell_n = r_dwell;
    if (estop) begin
      w_duty_n  = '0;
      w_rev_n   = 1'b0;
      w_state_n = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            w_tgt_n  = speed_mag(cmd_speed);
            w_step_n = (cmd_step == 8'd0) ? 8'd1 : cmd_step;
            if (w_sgn != r_dir) begin
              // Spinning: stop and dwell first. Stopped: flip right away.
              if (r_duty != 8'd0) w_rev_n = 1'b1;
              else                w_dir_n = w_sgn;
            end
            w_state_n = S_RAMP;
          end
        end
        S_RAMP: begin
          // Arrival is checked every cycle so a zero-length ramp exits at once.
          if (r_duty == w_goal) begin
            if (r_rev_pend) begin
              w_state_n = S_DWELL;
              w_dwell_n = '0;
            end else if (w_goal == 8'd0) begin
              w_state_n = S_IDLE;
            end else begin
              w_state_n = S_HOLD;
            end
          end else if (w_tick) begin
            w_duty_n = ramp_step(r_duty, w_goal, r_step);
          end
        end
        S_DWELL: begin
          w_duty_n = '0;
          if (w_tick) begin
            if (r_dwell == DWELL_LAST) begin
              w_dir_n   = ~r_dir;
              w_rev_n   = 1'b0;
              w_state_n = S_RAMP;
            end else begin
              w_dwell_n = r_dwell + 1'b1;
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_duty      <= '0;
      r_dir       <= 1'b1;
      r_tgt       <= '0;
      r_step      <= 8'd1;
      r_rev_pend  <= 1'b0;
      r_dwell     <= '0;
      r_ready_st  <= 1'b1;
      r_enable    <= 1'b0;
      r_busy      <= 1'b0;
      r_at_target <= 1'b1;
    end else begin
      r_state     <= w_state_n;
      r_duty      <= w_duty_n;
      r_dir       <= w_dir_n;
      r_tgt       <= w_tgt_n;
      r_step      <= w_step_n;
      r_rev_pend  <= w_rev_n;
      r_dwell     <= w_dwell_n;
      // Status flags are decoded from the next state so they line up with it.
      r_ready_st  <= (w_state_n == S_IDLE) || (w_state_n == S_HOLD);
      r_enable    <= (w_state_n == S_RAMP) || (w_state_n == S_HOLD);
      r_busy      <= (w_state_n == S_RAMP) || (w_state_n == S_DWELL);
      r_at_target <= (w_state_n == S_HOLD) || (w_state_n == S_IDLE);
    end
  end

  assign drv_duty      = r_duty;
  assign drv_direction = r_dir;
  assign drv_enable    = r_enable;
  assign busy          = r_busy;
  assign at_target     = r_at_target;

endmodule
